stage_seq: RTL and testbench
============================

Name: stage_seq

Overview:
- Parametrised multicycle stage sequencer. Replaces the hard-coded 4-state fetch/decode/execute/writeback controller in the core top.
- Generalises it to N stages, adds per-stage stall, trap redirect, a dwell watchdog, and retire/cycle counters for CSR use.
- Sits in the core top. Drives the `en_i` of each stage unit. Consumes each stage's ready and the CSR trap request.

Parameters:
- NUM_STAGES, 4: number of sequential stages, minimum 2.
- TRAP_STAGE, 1: stage index entered on trap, 0..NUM_STAGES-1.
- TIMEOUT, 255: maximum dwell cycles per stage before halt. 0 disables the watchdog.
- CNT_W, 32: width of the retire and cycle counters.
- IDX_W, max(1, clog2(NUM_STAGES)): stage index width, derived.

Ports:
- clk_i  in  1  clock, all logic on posedge.
- rst_i  in  1  reset, synchronous, active-high.
- stage_ready_i  in  NUM_STAGES  bit k = stage k has finished its work.
- stall_i  in  1  holds the current stage, blocks advance and freezes the watchdog.
- trap_i  in  1  redirect to TRAP_STAGE.
- stage_en_o  out  NUM_STAGES  one-hot enable of the current stage, all-zero when halted.
- stage_idx_o  out  IDX_W  current stage index.
- stage_first_o  out  1  high in the first cycle of any stage entry.
- retire_o  out  1  one-cycle pulse after the last stage completes.
- retire_cnt_o  out  CNT_W  count of retired instructions.
- cycle_cnt_o  out  CNT_W  free-running cycle count.
- timeout_o  out  1  sticky watchdog flag, high while halted.

Behaviour:
- Reset values:
  - stage_idx_o=0, stage_en_o=1 (bit 0 only), stage_first_o=1.
  - retire_o=0, retire_cnt_o=0, cycle_cnt_o=0, timeout_o=0, internal dwell counter=0.
- All outputs are registered; there are no combinational paths from input to output.
- Only stage_ready_i[stage_idx] is examined. All other ready bits are ignored.
- Next-state priority, highest first:
  1. rst_i
  2. trap_i
  3. halted
  4. stall_i
  5. advance
  6. hold
- Trap:
  - stage_idx<=TRAP_STAGE and stage_first<=1.
  - dwell<=0 and timeout<=0 (leaves halt).
  - No retire, even if the last stage is ready in the same cycle.
  - Trap while already in TRAP_STAGE re-enters it, so stage_first pulses again.
- Halted (timeout_o=1):
  - stage_en_o=0 and stage_first_o=0; stage_idx_o holds the stalled stage.
  - Ready and stall are ignored. Only trap or reset exits halt.
- Stall (stall_i=1, not halted, no trap):
  - Stage held and dwell frozen.
  - stage_first_o drops to 0 after the entry cycle.
- Advance (stage_ready_i[idx]=1, no stall):
  - Next cycle: idx<=idx+1, wrapping NUM_STAGES-1 -> 0. stage_first<=1, dwell<=0.
  - A stage can advance in its entry cycle, giving a minimum of 1 cycle per stage.
- Retire:
  - Advance out of stage NUM_STAGES-1 sets retire_o=1 in the next cycle, coincident with the stage 0 entry cycle.
  - retire_cnt increments in that same cycle and wraps modulo 2^CNT_W.
- Hold (not ready, no stall, not halted):
  - dwell<=dwell+1 and stage_first<=0.
  - When TIMEOUT!=0 and dwell==TIMEOUT-1 on a hold cycle, timeout<=1 and the sequencer halts next cycle.
  - Net effect: a stage that sits TIMEOUT consecutive non-stalled cycles without ready halts.
  - The dwell counter is clog2(TIMEOUT+1) wide and saturates, never wraps.
- cycle_cnt:
  - Increments every non-reset cycle, including halted and stalled cycles.
  - Wraps modulo 2^CNT_W.
- Reset mid-operation: next cycle is exactly the reset state. No pending retire or timeout survives.

Test Plan:
1. Defaults. Reset 2 cycles, then stage_ready_i=4'b1111 constant -> stage_idx_o sequences 0,1,2,3,0...; stage_first_o=1 every cycle; retire_o pulses every 4th cycle; retire_cnt_o=3 after 12 cycles.
2. Stall. In stage 2, stage_ready_i[2]=1 with stall_i=1 for 10 cycles -> idx stays 2, stage_first_o=0 after the entry cycle, timeout_o=0. Release stall -> idx=3 next cycle.
3. Trap. trap_i in stage 3 while stage_ready_i[3]=1 -> idx=1, no retire_o, retire_cnt_o unchanged. Trap in stage 1 -> stage_first_o re-pulses.
4. Watchdog. TIMEOUT=5, stage_ready_i=0 from stage 0 entry -> timeout_o=1 after 5 hold cycles, stage_en_o=0. Ready is then ignored; trap_i -> idx=1, timeout_o=0.
5. Wrap. CNT_W=4, 17 full instructions -> retire_cnt_o=1, cycle_cnt_o wraps consistently. Then assert rst_i mid-stage -> all reset values next cycle.
6. NUM_STAGES=2, TRAP_STAGE=0, TIMEOUT=0 -> alternation 0,1,0; 1000 idle cycles never set timeout_o; stage_idx_o is 1 bit.

Source files
------------

// File: rtl/stage_seq.sv
// N-stage multicycle sequencer with stall, trap redirect,
// dwell watchdog and retire/cycle counters.
module stage_seq #(
  parameter int NUM_STAGES = 4,
  parameter int TRAP_STAGE = 1,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 32,
  parameter int IDX_W      =
    (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_STAGES-1:0] stage_ready_i,
  input  logic                  stall_i,
  input  logic                  trap_i,
  output logic [NUM_STAGES-1:0] stage_en_o,
  output logic [IDX_W-1:0]      stage_idx_o,
  output logic                  stage_first_o,
  output logic                  retire_o,
  output logic [CNT_W-1:0]      retire_cnt_o,
  output logic [CNT_W-1:0]      cycle_cnt_o,
  output logic                  timeout_o
);

  localparam int DW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0] TRAP_IDX =
    IDX_W'(TRAP_STAGE);
  localparam logic [DW-1:0] TO_LIM =
    DW'(TIMEOUT - 1);
  localparam logic TO_ON = (TIMEOUT != 0);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             first_q, first_d;
  logic             ret_q, ret_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] ccnt_q, ccnt_d;
  logic             to_q, to_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             rdy;

  assign rdy = stage_ready_i[idx_q];

  // Next-state: trap > halted > stall > advance > hold
  always_comb begin
    idx_d   = idx_q;
    first_d = 1'b0;
    ret_d   = 1'b0;
    rcnt_d  = rcnt_q;
    ccnt_d  = ccnt_q + CNT_W'(1);
    to_d    = to_q;
    dwell_d = dwell_q;
    if (trap_i) begin
      idx_d   = TRAP_IDX;
      first_d = 1'b1;
      dwell_d = '0;
      to_d    = 1'b0;
    end else if (to_q) begin
      idx_d = idx_q;
    end else if (stall_i) begin
      idx_d = idx_q;
    end else if (rdy) begin
      first_d = 1'b1;
      dwell_d = '0;
      if (idx_q == LAST) begin
        idx_d  = '0;
        ret_d  = 1'b1;
        rcnt_d = rcnt_q + CNT_W'(1);
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      if (dwell_q != '1)
        dwell_d = dwell_q + DW'(1);
      if (TO_ON && dwell_q == TO_LIM)
        to_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      first_q <= 1'b1;
      ret_q   <= 1'b0;
      rcnt_q  <= '0;
      ccnt_q  <= '0;
      to_q    <= 1'b0;
      dwell_q <= '0;
    end else begin
      idx_q   <= idx_d;
      first_q <= first_d;
      ret_q   <= ret_d;
      rcnt_q  <= rcnt_d;
      ccnt_q  <= ccnt_d;
      to_q    <= to_d;
      dwell_q <= dwell_d;
    end
  end

  // One-hot enable decoded from registered state only
  always_comb begin
    stage_en_o = '0;
    if (!to_q)
      stage_en_o = NUM_STAGES'(1) << idx_q;
  end

  assign stage_idx_o   = idx_q;
  assign stage_first_o = first_q;
  assign retire_o      = ret_q;
  assign retire_cnt_o  = rcnt_q;
  assign cycle_cnt_o   = ccnt_q;
  assign timeout_o     = to_q;

endmodule

// File: tb/tb_stage_seq.sv
// Bench for stage_seq: directed + random stimulus
// against a behavioural model; two configurations.
module tb_stage_seq;

  localparam int N  = 4;
  localparam int TS = 1;
  localparam int TO = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  rdy;
  logic          stall;
  logic          trap;
  logic [N-1:0]  en;
  logic [1:0]    idx;
  logic          first;
  logic          ret;
  logic [CW-1:0] rcnt;
  logic [CW-1:0] ccnt;
  logic          tout;

  logic          rst2;
  logic [1:0]    rdy2;
  logic [1:0]    en2;
  logic          idx2;
  logic          first2;
  logic          ret2;
  logic [7:0]    rcnt2;
  logic [7:0]    ccnt2;
  logic          tout2;

  int checks = 0;
  int errors = 0;

  int m_idx, m_first, m_ret, m_rcnt;
  int m_ccnt, m_halt, m_dwell;

  always #5 clk = ~clk;

  stage_seq #(
    .NUM_STAGES(N), .TRAP_STAGE(TS),
    .TIMEOUT(TO), .CNT_W(CW)
  ) u_dut (
    .clk_i(clk), .rst_i(rst),
    .stage_ready_i(rdy), .stall_i(stall),
    .trap_i(trap), .stage_en_o(en),
    .stage_idx_o(idx), .stage_first_o(first),
    .retire_o(ret), .retire_cnt_o(rcnt),
    .cycle_cnt_o(ccnt), .timeout_o(tout)
  );

  stage_seq #(
    .NUM_STAGES(2), .TRAP_STAGE(0),
    .TIMEOUT(0), .CNT_W(8)
  ) u_dut2 (
    .clk_i(clk), .rst_i(rst2),
    .stage_ready_i(rdy2), .stall_i(1'b0),
    .trap_i(1'b0), .stage_en_o(en2),
    .stage_idx_o(idx2), .stage_first_o(first2),
    .retire_o(ret2), .retire_cnt_o(rcnt2),
    .cycle_cnt_o(ccnt2), .timeout_o(tout2)
  );

  task automatic chk(input string tag,
                     input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // Spec-level model: one call per clock edge.
  task automatic model_step();
    int mod;
    mod = 1 << CW;
    if (rst) begin
      m_idx = 0; m_first = 1; m_ret = 0;
      m_rcnt = 0; m_ccnt = 0;
      m_halt = 0; m_dwell = 0;
      return;
    end
    m_ccnt = (m_ccnt + 1) % mod;
    m_ret = 0;
    if (trap) begin
      m_idx = TS; m_first = 1;
      m_dwell = 0; m_halt = 0;
    end else if (m_halt != 0 || stall) begin
      m_first = 0;
    end else if (rdy[m_idx]) begin
      if (m_idx == N - 1) begin
        m_ret = 1;
        m_rcnt = (m_rcnt + 1) % mod;
      end
      m_idx = (m_idx + 1) % N;
      m_first = 1;
      m_dwell = 0;
    end else begin
      m_first = 0;
      m_dwell++;
      if (TO != 0 && m_dwell >= TO)
        m_halt = 1;
    end
  endtask

  task automatic cmp_all();
    int exp_en;
    exp_en = (m_halt != 0) ? 0 : (1 << m_idx);
    chk("idx", int'(idx), m_idx);
    chk("en", int'(en), exp_en);
    chk("first", int'(first), m_first);
    chk("retire", int'(ret), m_ret);
    chk("rcnt", int'(rcnt), m_rcnt);
    chk("ccnt", int'(ccnt), m_ccnt);
    chk("timeout", int'(tout), m_halt);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    cmp_all();
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    rdy = '1; stall = 0; trap = 0; rst = 0;
    while (m_idx != target && n < 16) begin
      cyc();
      n++;
    end
    chk("reach_stage", m_idx, target);
  endtask

  initial begin
    int r, e2;
    rst = 1; rdy = '0; stall = 0; trap = 0;
    rst2 = 1; rdy2 = '0;
    @(posedge clk); #1;
    cyc();
    cmp_all();

    // Defaults: all ready, one stage per cycle
    rst = 0; rdy = '1;
    for (int i = 0; i < 12; i++) cyc();
    chk("rcnt_after12", int'(rcnt), 3);
    chk("idx_after12", int'(idx), 0);

    // Stall in stage 2 with ready high
    run_to(2);
    stall = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("stall_idx", int'(idx), 2);
    end
    chk("stall_first", int'(first), 0);
    chk("stall_tout", int'(tout), 0);
    stall = 0;
    cyc();
    chk("stall_release", int'(idx), 3);

    // Trap in last stage while ready: no retire
    r = m_rcnt;
    trap = 1;
    cyc();
    chk("trap_idx", int'(idx), 1);
    chk("trap_noret", int'(ret), 0);
    chk("trap_rcnt", int'(rcnt), r);
    cyc();
    chk("retrap_first", int'(first), 1);
    trap = 0;

    // Watchdog from stage 0 entry
    run_to(0);
    rdy = '0;
    for (int i = 0; i < 5; i++) cyc();
    chk("wd_tout", int'(tout), 1);
    chk("wd_en", int'(en), 0);
    rdy = '1;
    for (int i = 0; i < 4; i++) cyc();
    chk("wd_hold_idx", int'(idx), 0);
    trap = 1;
    cyc();
    trap = 0;
    chk("wd_exit_idx", int'(idx), 1);
    chk("wd_exit_tout", int'(tout), 0);

    // Counter wrap over 17 instructions
    run_to(0);
    r = m_rcnt;
    for (int i = 0; i < 17 * N; i++) cyc();
    chk("wrap_rcnt", int'(rcnt), (r + 1) % 16);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(63) == 0);
      trap  = ($urandom_range(15) == 0);
      stall = ($urandom_range(3) == 0);
      rdy   = N'($urandom);
      if ($urandom_range(7) == 0) rdy = '0;
      cyc();
    end

    // Reset mid-stage
    rst = 0; trap = 0; stall = 0;
    run_to(2);
    rdy = '0;
    cyc(); cyc();
    rst = 1;
    cyc();
    chk("rst_idx", int'(idx), 0);
    chk("rst_first", int'(first), 1);
    chk("rst_ccnt", int'(ccnt), 0);
    rst = 0;

    // Two-stage config, watchdog disabled
    @(posedge clk); #1;
    rst2 = 0; rdy2 = 2'b11;
    e2 = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      e2 = 1 - e2;
      chk("n2_idx", int'(idx2), e2);
      chk("n2_first", int'(first2), 1);
    end
    rdy2 = 2'b00;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (tout2 !== 1'b0 || idx2 !== 1'(e2)) begin
        chk("n2_idle_tout", int'(tout2), 0);
        chk("n2_idle_idx", int'(idx2), e2);
        break;
      end
    end
    chk("n2_final_tout", int'(tout2), 0);
    chk("n2_final_en", int'(en2), 1 << e2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
